fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising-edge active.
REQ-002 SHALL have ports: RST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: RUN  in  1  fetch enable, level.
REQ-004 SHALL have ports: JMP  in  1  load-PC request, one-cycle pulse.
REQ-005 SHALL have ports: JA  in  8  jump target address.
REQ-006 SHALL have ports: PA  out  8  program memory address.
REQ-007 SHALL have ports: nOE  out  1  program memory read strobe, active-low.
REQ-008 SHALL have ports: nWE  out  1  program memory write strobe, constant 1.
REQ-009 SHALL have ports: ID  in  15  memory read data; OP=ID[14:10], SR=ID[9:7], LR=ID[6:4], IM=ID[3:0].
REQ-010 SHALL have ports: INST  out  15  captured instruction word.
REQ-011 SHALL have ports: INST_PA  out  8  address INST was fetched from.
REQ-012 SHALL have ports: VALID  out  1  INST valid to decode stage.
REQ-013 SHALL have ports: READY  in  1  decode stage accepts INST.
REQ-014 SHALL have ports: HALT  out  1  halt instruction fetched.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, STROBE, HOLD, HALTED.
REQ-016 IDLE: nOE=1; RUN=1 at edge -> ADDR.
REQ-017 ADDR: PA=PC, nOE=1 (one setup cycle) -> STROBE.
REQ-018 STROBE: PA=PC, nOE=0 for exactly one cycle; at closing edge INST<=ID, INST_PA<=PC, PC<=PC+1, VALID<=1 -> HOLD.
REQ-019 HOLD: nOE=1, VALID held, INST/INST_PA stable; READY=1 at edge -> VALID<=0, then ADDR if RUN=1 else IDLE.
REQ-020 Throughput SHALL be one instruction per 3 cycles with READY and RUN held 1; VALID rises 2 cycles after entering ADDR.
REQ-021 PC SHALL be 8 bits, wrap 8'hFF -> 8'h00 without flag.
REQ-022 RUN deasserted in ADDR/STROBE SHALL NOT abort the fetch in progress; FSM stops in IDLE after handoff.
REQ-023 JMP=1 at any edge SHALL take priority: PC<=JA, VALID<=0, pending capture discarded, HALT<=0, next state ADDR if RUN=1 else IDLE.
REQ-024 JMP and READY together SHALL behave as JMP alone (held INST dropped).
REQ-025 PA SHALL equal PC in all states; nWE SHALL be 1 always.

Reset
REQ-026 RST=0 SHALL asynchronously force state IDLE, PC=8'h00, PA=8'h00, nOE=1, nWE=1, INST=15'h0000, INST_PA=8'h00, VALID=0, HALT=0.
REQ-027 RST asserted mid-STROBE SHALL abort read, nOE=1 immediately; no capture.
REQ-028 Release of RST SHALL take effect at next rising CLK edge only.

Configuration
REQ-029 Macro FETCH_HALT_DETECT_EN defined: capture with ID[14:10]=5'b11111 sets HALT<=1; after READY handoff FSM enters HALTED (nOE=1, no fetch) until JMP or reset.
REQ-030 Macro FETCH_HALT_DETECT_EN undefined: HALT tied 0, HALTED unreachable, 5'b11111 fetched as ordinary opcode.

Verification
REQ-031 Memory 0:15'h0F00, 1:15'h00F0, 2:15'h000F; RUN=1, READY=1 -> INST 15'h0F00/00F0/000F with INST_PA 0/1/2, VALID 1 cycle each, 3-cycle spacing, nOE low 1 cycle per fetch.
REQ-032 READY=0 for 5 cycles in HOLD -> VALID and INST=15'h0F00 held, nOE=1, PA=8'h01 stable; READY=1 -> next fetch from 8'h01.
REQ-033 PC at 8'hFF (via JMP JA=8'hFF) -> INST_PA=8'hFF, next fetch PA=8'h00.
REQ-034 JMP JA=8'h40 asserted in STROBE -> no VALID for aborted fetch; next INST_PA=8'h40.
REQ-035 RST=0 pulsed mid-STROBE -> all outputs at reset values same cycle, PA=8'h00, restart from 8'h00.
REQ-036 With FETCH_HALT_DETECT_EN, memory 1:15'h7C00 -> HALT=1 with INST_PA=8'h01, no further nOE pulses; JMP JA=8'h00 -> HALT=0, fetch resumes.

Source files
------------

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer for a small program memory. It presents the PC
// on PA, pulses the active-low read strobe nOE for one cycle per fetch, and
// captures the returned word for the decode stage with a VALID/READY handoff.
// Steady-state throughput is one instruction every three cycles.
//
// Optional feature (macro FETCH_HALT_DETECT_EN):
//   defined   : fetching opcode 5'b11111 raises HALT. After the decode stage
//               accepts that word, the FSM parks in HALTED until JMP or reset.
//   undefined : HALT is tied low and 5'b11111 is an ordinary opcode.
//
// Ports
//   CLK      in   1   system clock, rising edge
//   RST      in   1   asynchronous active-low reset
//   RUN      in   1   fetch enable (level)
//   JMP      in   1   load-PC request (one-cycle pulse), highest priority
//   JA       in   8   jump target address
//   PA       out  8   program memory address (always equals PC)
//   nOE      out  1   program memory read strobe, active low
//   nWE      out  1   program memory write strobe, constant 1
//   ID       in  15   memory read data {OP[4:0], SR[2:0], LR[2:0], IM[3:0]}
//   INST     out 15   captured instruction word
//   INST_PA  out  8   address INST was fetched from
//   VALID    out  1   INST valid to decode stage
//   READY    in   1   decode stage accepts INST
//   HALT     out  1   halt instruction fetched
//
// FSM
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | not fetching; waits for RUN
//   ADDR     | address setup cycle, PA=PC, nOE=1
//   STROBE   | read cycle, nOE=0; word captured at the closing edge
//   HOLD     | INST held with VALID=1 until READY
//   HALTED   | halt opcode handed off; no fetches until JMP or reset
// ----------------------------------------------------------------------------
module fetch_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RUN,
    input  logic        JMP,
    input  logic [7:0]  JA,
    output logic [7:0]  PA,
    output logic        nOE,
    output logic        nWE,
    input  logic [14:0] ID,
    output logic [14:0] INST,
    output logic [7:0]  INST_PA,
    output logic        VALID,
    input  logic        READY,
    output logic        HALT
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [4:0] OP_HALT  = 5'b11111;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [7:0]  pc;
    logic [14:0] inst_q;
    logic [7:0]  inst_pa_q;
    logic        valid_q;
    logic        halt_q;

    // ------------------------------------------------------------------------
    // Next-state logic. JMP overrides every state, including HALTED.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (JMP) begin
            state_nxt = RUN ? S_ADDR : S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (RUN) state_nxt = S_ADDR;
                S_ADDR:   state_nxt = S_STROBE;
                S_STROBE: state_nxt = S_HOLD;
                S_HOLD: begin
                    if (READY) begin
                        if (halt_q)
                            state_nxt = S_HALTED;
                        else
                            state_nxt = RUN ? S_ADDR : S_IDLE;
                    end
                end
                S_HALTED: state_nxt = S_HALTED;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State, PC and capture registers. A JMP on the capture edge discards the
    // word being read and drops any word held for decode.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            pc        <= 8'h00;
            inst_q    <= 15'h0000;
            inst_pa_q <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (JMP) begin
                pc      <= JA;
                valid_q <= 1'b0;
            end else begin
                case (state)
                    S_STROBE: begin
                        inst_q    <= ID;
                        inst_pa_q <= pc;
                        pc        <= pc + 8'd1;
                        valid_q   <= 1'b1;
                    end
                    S_HOLD: begin
                        if (READY) valid_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    // HALT follows the opcode of the most recent capture and stays set while
    // parked in HALTED; only JMP or reset clears it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            halt_q <= 1'b0;
        end else if (JMP) begin
            halt_q <= 1'b0;
        end else if (state == S_STROBE) begin
            halt_q <= (ID[14:10] == OP_HALT);
        end
    end
`else
    assign halt_q = 1'b0;
`endif

    // Strobe decoded straight from state so reset releases it immediately.
    assign PA      = pc;
    assign nOE     = (state != S_STROBE);
    assign nWE     = 1'b1;
    assign INST    = inst_q;
    assign INST_PA = inst_pa_q;
    assign VALID   = valid_q;
    assign HALT    = halt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A 256-word program memory drives ID from PA.
// Directed sequences use the three-cycle fetch rhythm: counting samples k=1,2,..
// after the first active edge from IDLE/ADDR entry, nOE is low when k%3==2,
// VALID is high when k%3==0, and PA is base + k/3.
// The randomized phase uses a scoreboard: the expected fetch address
// advances by one per delivered word and is reloaded by JMP or reset.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        tb_CLK = 1'b0;
    logic        RST;
    logic        RUN;
    logic        JMP;
    logic [7:0]  JA;
    logic [7:0]  PA;
    logic        nOE;
    logic        nWE;
    logic [14:0] ID;
    logic [14:0] INST;
    logic [7:0]  INST_PA;
    logic        VALID;
    logic        READY;
    logic        HALT;

    logic [14:0] mem [0:255];

    int n_chk = 0;
    int n_err = 0;

    always #5 tb_CLK = ~tb_CLK;

    assign ID = mem[PA];

    fetch_unit dut (
        .CLK     (tb_CLK),
        .RST     (RST),
        .RUN     (RUN),
        .JMP     (JMP),
        .JA      (JA),
        .PA      (PA),
        .nOE     (nOE),
        .nWE     (nWE),
        .ID      (ID),
        .INST    (INST),
        .INST_PA (INST_PA),
        .VALID   (VALID),
        .READY   (READY),
        .HALT    (HALT)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pa"},      PA,      8'h00);
        chk({tag, "_noe"},     nOE,     1'b1);
        chk({tag, "_nwe"},     nWE,     1'b1);
        chk({tag, "_inst"},    INST,    15'h0000);
        chk({tag, "_inst_pa"}, INST_PA, 8'h00);
        chk({tag, "_valid"},   VALID,   1'b0);
        chk({tag, "_halt"},    HALT,    1'b0);
    endtask

    // Assert reset at the current time, check reset values, wait to the next
    // falling edge; the caller sets inputs and releases RST there.
    task automatic do_reset(input string tag);
        RST = 1'b0;
        JMP = 1'b0;
        #1;
        chk_reset_vals(tag);
        @(negedge tb_CLK);
    endtask

    task automatic fetch_pattern(input string tag, input int k0, input int nk, input logic [7:0] base);
        for (int k = k0; k < k0 + nk; k++) begin
            logic [7:0] idx;
            logic [7:0] ipa;
            @(negedge tb_CLK);
            JMP = 1'b0;
            idx = base + 8'(k / 3);
            chk({tag, "_pa"},  PA,    idx);
            chk({tag, "_noe"}, nOE,   (k % 3 == 2) ? 1'b0 : 1'b1);
            chk({tag, "_val"}, VALID, (k % 3 == 0) ? 1'b1 : 1'b0);
            chk({tag, "_nwe"}, nWE,   1'b1);
            if (k % 3 == 0) begin
                ipa = base + 8'(k / 3 - 1);
                chk({tag, "_ipa"},  INST_PA, ipa);
                chk({tag, "_inst"}, INST,    mem[ipa]);
            end
`ifndef FETCH_HALT_DETECT_EN
            chk({tag, "_halt"}, HALT, 1'b0);
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  exp_addr;
        logic        prev_valid, prev_ready, prev_jmp, prev_noe_low;
        logic [7:0]  prev_ja, prev_ipa;
        logic [14:0] prev_inst;
        int          nwords;

        for (int i = 0; i < 256; i++) begin
            mem[i] = 15'($urandom);
`ifdef FETCH_HALT_DETECT_EN
            if (mem[i][14:10] == 5'b11111) mem[i][14] = 1'b0;
`endif
        end
        mem[0] = 15'h0F00;
        mem[1] = 15'h00F0;
        mem[2] = 15'h000F;
`ifndef FETCH_HALT_DETECT_EN
        mem[8'h40] = 15'h7C00;
`endif

        RST = 1'b0; RUN = 1'b0; JMP = 1'b0; JA = 8'h00; READY = 1'b0;
        @(negedge tb_CLK);

        // Basic stream, READY and RUN held high.
        do_reset("rst0");
        RUN = 1'b1; READY = 1'b1; RST = 1'b1;
        fetch_pattern("stream", 1, 9, 8'h00);

        // Decode stall for five cycles.
        do_reset("rst1");
        RUN = 1'b1; READY = 1'b0; RST = 1'b1;
        fetch_pattern("stall_pre", 1, 3, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_CLK);
            chk("stall_valid", VALID,   1'b1);
            chk("stall_inst",  INST,    15'h0F00);
            chk("stall_ipa",   INST_PA, 8'h00);
            chk("stall_noe",   nOE,     1'b1);
            chk("stall_pa",    PA,      8'h01);
        end
        READY = 1'b1;
        @(negedge tb_CLK);
        chk("stall_release_valid", VALID, 1'b0);
        chk("stall_release_noe",   nOE,   1'b1);
        chk("stall_release_pa",    PA,    8'h01);
        fetch_pattern("stall_post", 2, 2, 8'h01);

        // PC wrap from 8'hFF.
        do_reset("rst2");
        RUN = 1'b1; READY = 1'b1; JMP = 1'b1; JA = 8'hFF; RST = 1'b1;
        fetch_pattern("wrap", 1, 5, 8'hFF);

        // JMP during STROBE discards the capture.
        do_reset("rst3");
        RUN = 1'b1; READY = 1'b1; RST = 1'b1;
        fetch_pattern("jmp_pre", 1, 2, 8'h00);
        JMP = 1'b1; JA = 8'h40;
        fetch_pattern("jmp_post", 1, 5, 8'h40);

        // Reset pulsed mid-STROBE of the second fetch.
        do_reset("rst4");
        RUN = 1'b1; READY = 1'b1; RST = 1'b1;
        fetch_pattern("mid_pre", 1, 5, 8'h00);
        #2;
        RST = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge tb_CLK);
        chk_reset_vals("mid_rst_hold");
        RST = 1'b1;
        fetch_pattern("mid_post", 1, 6, 8'h00);

`ifdef FETCH_HALT_DETECT_EN
        // Halt opcode at address 1.
        mem[1] = 15'h7C00;
        do_reset("rst5");
        RUN = 1'b1; READY = 1'b1; RST = 1'b1;
        fetch_pattern("halt_pre", 1, 6, 8'h00);
        chk("halt_set", HALT, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge tb_CLK);
            chk("halted_noe",   nOE,   1'b1);
            chk("halted_halt",  HALT,  1'b1);
            chk("halted_valid", VALID, 1'b0);
            chk("halted_pa",    PA,    8'h02);
        end
        JMP = 1'b1; JA = 8'h00;
        fetch_pattern("halt_resume", 1, 3, 8'h00);
        chk("halt_cleared", HALT, 1'b0);
        mem[1] = 15'h00F0;
`endif

        // Randomized phase against the scoreboard.
        do_reset("rst_rnd");
        RUN = 1'b1; READY = 1'b1; RST = 1'b1;
        exp_addr = 8'h00; prev_valid = 1'b0; prev_ready = 1'b1; prev_jmp = 1'b0;
        prev_noe_low = 1'b0; prev_ja = 8'h00; prev_ipa = 8'h00; prev_inst = 15'h0;
        nwords = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge tb_CLK);
            if (prev_jmp) begin
                exp_addr = prev_ja;
                chk("rnd_jmp_valid", VALID, 1'b0);
            end else if (prev_valid) begin
                chk("rnd_handoff_valid", VALID, prev_ready ? 1'b0 : 1'b1);
            end
            if (VALID && !prev_valid) begin
                chk("rnd_ipa",  INST_PA, exp_addr);
                chk("rnd_inst", INST,    mem[exp_addr]);
                exp_addr = exp_addr + 8'd1;
                nwords++;
            end else if (VALID) begin
                chk("rnd_inst_stable", INST,    prev_inst);
                chk("rnd_ipa_stable",  INST_PA, prev_ipa);
            end
            chk("rnd_pa",   PA,   exp_addr);
            chk("rnd_nwe",  nWE,  1'b1);
            chk("rnd_halt", HALT, 1'b0);
            if (!nOE) begin
                chk("rnd_noe_width", prev_noe_low, 1'b0);
                chk("rnd_noe_valid", VALID, 1'b0);
            end
            prev_noe_low = !nOE;
            prev_valid   = VALID;
            prev_inst    = INST;
            prev_ipa     = INST_PA;

            if (!RST) begin
                RST = 1'b1;
                JMP = 1'b0;
            end else if ($urandom_range(249, 0) == 0) begin
                RST = 1'b0;
                JMP = 1'b0;
                exp_addr     = 8'h00;
                prev_valid   = 1'b0;
                prev_noe_low = 1'b0;
            end else begin
                RUN   = ($urandom_range(7, 0) != 0);
                READY = ($urandom_range(2, 0) != 0);
                JMP   = ($urandom_range(19, 0) == 0);
                JA    = 8'($urandom);
            end
            prev_jmp   = JMP;
            prev_ja    = JA;
            prev_ready = READY;
        end
        chk("rnd_progress", (nwords > 50) ? 1'b1 : 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
